// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants and helpers shared by the VGA sync generator.
package vga_timing_pkg;

    localparam int COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

    localparam int DEF_CLK_DIV  = 2;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    function automatic int h_total(int active, int fp, int sync, int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(int active, int fp, int sync, int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/pix_tick_div.sv
// System-clock to pixel-rate divider; adv marks the edge on which the pixel counters step.
module pix_tick_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic adv,
    output logic pix_tick
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div;

    // With CLK_DIV = 1 the divider sits at 0 == DIV_LAST, so adv follows en.
    assign adv = en && (div == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div      <= '0;
            pix_tick <= 1'b0;
        end else begin
            pix_tick <= adv;
            if (en) div <= adv ? '0 : div + 1'b1;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel/line counters with registered sync, blanking and pulse decode.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int   CLK_DIV  = DEF_CLK_DIV,
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic SYNC_ACT = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       En,
    output logic       Pix_Tick,
    output logic       HSync,
    output logic       VSync,
    output logic       Video_On,
    output logic [9:0] X_PIX,
    output logic [9:0] Y_PIX,
    output logic       Line_End,
    output logic       Frame_Start
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);
    localparam coord_t H_ACT  = coord_t'(H_ACTIVE);
    localparam coord_t V_ACT  = coord_t'(V_ACTIVE);
    localparam coord_t HS_BEG = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t HS_END = coord_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam coord_t VS_BEG = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t VS_END = coord_t'(V_ACTIVE + V_FP + V_SYNC);

    logic   adv;
    logic   x_wrap;
    logic   y_wrap;
    coord_t x_nxt;
    coord_t y_nxt;

    pix_tick_div #(
        .CLK_DIV(CLK_DIV)
    ) u_div (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (En),
        .adv     (adv),
        .pix_tick(Pix_Tick)
    );

    always_comb begin
        x_wrap = (X_PIX == H_LAST);
        y_wrap = (Y_PIX == V_LAST);
        x_nxt  = X_PIX;
        y_nxt  = Y_PIX;
        if (adv) begin
            x_nxt = x_wrap ? '0 : X_PIX + 1'b1;
            if (x_wrap) y_nxt = y_wrap ? '0 : Y_PIX + 1'b1;
        end
    end

    // Level outputs decode the next counter value so they land on the same edge as the counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            X_PIX       <= '0;
            Y_PIX       <= '0;
            Video_On    <= 1'b0;
            HSync       <= ~SYNC_ACT;
            VSync       <= ~SYNC_ACT;
            Line_End    <= 1'b0;
            Frame_Start <= 1'b0;
        end else begin
            Line_End    <= adv && x_wrap;
            Frame_Start <= adv && x_wrap && y_wrap;
            if (adv) begin
                X_PIX    <= x_nxt;
                Y_PIX    <= y_nxt;
                Video_On <= (x_nxt < H_ACT) && (y_nxt < V_ACT);
                HSync    <= (x_nxt >= HS_BEG && x_nxt < HS_END) ? SYNC_ACT : ~SYNC_ACT;
                VSync    <= (y_nxt >= VS_BEG && y_nxt < VS_END) ? SYNC_ACT : ~SYNC_ACT;
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: full-size line timing plus reduced-size frames for frame-level corners.
module tb_vga_sync_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Instance A: default 640x480 timing, CLK_DIV = 2
    logic rst_n_a = 1'b0, en_a = 1'b0;
    logic tick_a, hs_a, vs_a, vid_a, le_a, fs_a;
    logic [9:0] x_a, y_a;
    vga_sync_gen dut_a (
        .clk(clk), .rst_n(rst_n_a), .En(en_a), .Pix_Tick(tick_a), .HSync(hs_a), .VSync(vs_a),
        .Video_On(vid_a), .X_PIX(x_a), .Y_PIX(y_a), .Line_End(le_a), .Frame_Start(fs_a)
    );

    // Instance S: 32x19 total (16x12 active), CLK_DIV = 2, frame = 1216 clks
    logic rst_n_s = 1'b0, en_s = 1'b0;
    logic tick_s, hs_s, vs_s, vid_s, le_s, fs_s;
    logic [9:0] x_s, y_s;
    vga_sync_gen #(
        .CLK_DIV(2), .H_ACTIVE(16), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_ACT(1'b0)
    ) dut_s (
        .clk(clk), .rst_n(rst_n_s), .En(en_s), .Pix_Tick(tick_s), .HSync(hs_s), .VSync(vs_s),
        .Video_On(vid_s), .X_PIX(x_s), .Y_PIX(y_s), .Line_End(le_s), .Frame_Start(fs_s)
    );

    // Instance O: same reduced timing, CLK_DIV = 1, frame = 608 clks
    logic rst_n_o = 1'b0, en_o = 1'b0;
    logic tick_o, hs_o, vs_o, vid_o, le_o, fs_o;
    logic [9:0] x_o, y_o;
    vga_sync_gen #(
        .CLK_DIV(1), .H_ACTIVE(16), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_ACT(1'b0)
    ) dut_o (
        .clk(clk), .rst_n(rst_n_o), .En(en_o), .Pix_Tick(tick_o), .HSync(hs_o), .VSync(vs_o),
        .Video_On(vid_o), .X_PIX(x_o), .Y_PIX(y_o), .Line_End(le_o), .Frame_Start(fs_o)
    );

    typedef struct {
        int   tick;
        int   x;
        int   y;
        logic vid;
        logic hs;
        logic vs;
        logic le;
    } vec_t;

    vec_t vecs[11];

    int ticks_a     = 0;
    int hs_low_a    = 0;
    int le_last_a   = -1;
    int le_period_a = 0;

    task automatic run_a_to(input int target, output bit ok);
        int guard;
        guard = (target - ticks_a) * 2 + 10;
        while (ticks_a < target && guard > 0) begin
            step();
            guard--;
            if (tick_a) ticks_a++;
            if (hs_a == 1'b0) hs_low_a++;
            if (le_a) begin
                if (le_last_a >= 0) le_period_a = cyc - le_last_a;
                le_last_a = cyc;
            end
        end
        ok = (ticks_a == target);
    endtask

    initial begin
        bit   ok;
        int   bad, seen, nfs, vid_cnt, vs_low, zeros, first_fs;
        int   fs_e[2];
        logic [9:0] x_hold;

        vecs[0]  = '{2,    2,   0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{639,  639, 0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{640,  640, 0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{655,  655, 0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{656,  656, 0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{751,  751, 0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{752,  752, 0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{799,  799, 0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{800,  0,   1, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[9]  = '{1439, 639, 1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{1600, 0,   2, 1'b1, 1'b1, 1'b1, 1'b1};

        // ---------------- reset values and first tick, default timing
        en_a = 1'b1;
        repeat (3) step();
        check("rst_x", x_a, 0);
        check("rst_y", y_a, 0);
        check("rst_vid", vid_a, 0);
        check("rst_hs", hs_a, 1);
        check("rst_vs", vs_a, 1);
        check("rst_pulses", {tick_a, le_a, fs_a}, 0);
        #3 rst_n_a = 1'b1;
        step();
        check("first_clk_tick", tick_a, 0);
        check("first_clk_x", x_a, 0);
        check("first_clk_vid", vid_a, 0);
        step();
        check("second_clk_tick", tick_a, 1);
        check("second_clk_x", x_a, 1);
        ticks_a = 1;

        // ---------------- table: line decode across one and a half lines
        foreach (vecs[i]) begin
            run_a_to(vecs[i].tick, ok);
            check($sformatf("v%0d_reached", i), ok, 1);
            check($sformatf("v%0d_x", i), x_a, vecs[i].x);
            check($sformatf("v%0d_y", i), y_a, vecs[i].y);
            check($sformatf("v%0d_vid", i), vid_a, vecs[i].vid);
            check($sformatf("v%0d_hs", i), hs_a, vecs[i].hs);
            check($sformatf("v%0d_vs", i), vs_a, vecs[i].vs);
            check($sformatf("v%0d_le", i), le_a, vecs[i].le);
            check($sformatf("v%0d_tick", i), tick_a, 1);
        end
        check("hs_low_clks_2lines", hs_low_a, 384);
        check("line_end_period", le_period_a, 1600);

        // ---------------- enable stall at X = 320
        run_a_to(1920, ok);
        check("stall_reached", ok, 1);
        check("stall_x0", x_a, 320);
        en_a = 1'b0;
        bad = 0;
        for (int i = 0; i < 37; i++) begin
            step();
            if (tick_a || le_a || fs_a || x_a != 10'd320 || y_a != 10'd2 || vid_a != 1'b1) bad++;
        end
        check("stall_hold", bad, 0);
        en_a = 1'b1;
        seen = 0;
        bad  = 0;
        for (int i = 0; i < 5 && seen == 0; i++) begin
            step();
            if (tick_a) seen = 1;
            else if (x_a != 10'd320) bad++;
        end
        check("resume_tick_seen", seen, 1);
        check("resume_no_skip_before", bad, 0);
        check("resume_x", x_a, 321);
        rst_n_a = 1'b0;

        // ---------------- reduced timing: frame period, VSync width, active area
        en_s = 1'b1;
        repeat (2) step();
        check("s_rst_vs", vs_s, 1);
        #3 rst_n_s = 1'b1;
        nfs = 0; vid_cnt = 0; vs_low = 0;
        fs_e[0] = 0; fs_e[1] = 0;
        for (int e = 1; e <= 2 * 1216 + 10 && nfs < 2; e++) begin
            step();
            if (fs_s) begin
                fs_e[nfs] = e;
                nfs++;
                if (nfs == 1) begin
                    check("s_fs_x", x_s, 0);
                    check("s_fs_y", y_s, 0);
                    check("s_fs_le", le_s, 1);
                end
            end
            if (nfs == 1) begin
                if (tick_s && vid_s) vid_cnt++;
                if (!vs_s) vs_low++;
            end
        end
        check("s_fs_count", nfs, 2);
        check("s_first_fs_edge", fs_e[0], 1216);
        check("s_fs_period", fs_e[1] - fs_e[0], 1216);
        check("s_vid_ticks", vid_cnt, 192);
        check("s_vs_low_clks", vs_low, 128);

        // ---------------- asynchronous reset mid-frame, inside both sync pulses
        seen = 0;
        for (int i = 0; i < 2500 && seen == 0; i++) begin
            step();
            if (x_s == 10'd22 && y_s == 10'd14) seen = 1;
        end
        check("s_pos_reached", seen, 1);
        check("s_pre_hs", hs_s, 0);
        check("s_pre_vs", vs_s, 0);
        #2 rst_n_s = 1'b0;
        #1;
        check("async_x", x_s, 0);
        check("async_y", y_s, 0);
        check("async_vid", vid_s, 0);
        check("async_hs", hs_s, 1);
        check("async_vs", vs_s, 1);
        check("async_pulses", {tick_s, le_s, fs_s}, 0);
        step();
        #3 rst_n_s = 1'b1;
        first_fs = 0;
        for (int e = 1; e <= 1216 + 10 && first_fs == 0; e++) begin
            step();
            if (e == 2) begin
                check("restart_x", x_s, 1);
                check("restart_y", y_s, 0);
            end
            if (fs_s) first_fs = e;
        end
        check("restart_first_fs_edge", first_fs, 1216);
        rst_n_s = 1'b0;

        // ---------------- CLK_DIV = 1 variant
        en_o = 1'b1;
        repeat (2) step();
        #3 rst_n_o = 1'b1;
        nfs = 0; zeros = 0;
        fs_e[0] = 0; fs_e[1] = 0;
        for (int e = 1; e <= 2 * 608 + 10 && nfs < 2; e++) begin
            step();
            if (!tick_o) zeros++;
            if (fs_o) begin
                fs_e[nfs] = e;
                nfs++;
            end
        end
        check("o_tick_always_high", zeros, 0);
        check("o_fs_count", nfs, 2);
        check("o_first_fs_edge", fs_e[0], 608);
        check("o_fs_period", fs_e[1] - fs_e[0], 608);
        en_o = 1'b0;
        step();
        x_hold = x_o;
        repeat (3) step();
        check("o_en_low_tick", tick_o, 0);
        check("o_en_low_x_hold", x_o, x_hold);
        check("o_en_low_sync", {hs_o, vs_o, vid_o, y_o[0], le_o, fs_o} === 6'bxxxxxx, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Generates 640x480@60 Hz VGA timing: pixel-rate tick, horizontal/vertical counters, HSync/VSync, Video_On and pixel coordinates.
- Sits directly upstream of the pixel colour stage and drives its X_PIX, Y_PIX and Video_On inputs.
- HSync/VSync go straight to the connector, aligned with the colour stage output.
- All outputs are registered; counters advance once per pixel tick derived from the system clock.

Parameters:
- CLK_DIV, 2, system clocks per pixel (50 MHz -> 25 MHz); legal range 1..16.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch in pixels.
- H_SYNC, 96, horizontal sync width in pixels.
- H_BP, 48, horizontal back porch in pixels.
- V_ACTIVE, 480, visible lines per frame.
- V_FP, 10, vertical front porch in lines.
- V_SYNC, 2, vertical sync width in lines.
- V_BP, 33, vertical back porch in lines.
- SYNC_ACT, 0, active level of HSync/VSync (0 = active-low).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- En  input  1  synchronous enable; low freezes the divider, counters and outputs.
- Pix_Tick  output  1  one-clk pulse marking each pixel period.
- HSync  output  1  horizontal sync.
- VSync  output  1  vertical sync.
- Video_On  output  1  high inside the 640x480 active area.
- X_PIX  output  10  current horizontal count, 0..H_TOTAL-1.
- Y_PIX  output  10  current vertical count, 0..V_TOTAL-1.
- Line_End  output  1  one-clk pulse on the tick where X_PIX wraps to 0.
- Frame_Start  output  1  one-clk pulse on the tick where X_PIX and Y_PIX both wrap to 0.

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800; V_TOTAL = 525.
- Reset (async assert, sync-style deassert at the next clk edge):
  - divider = 0, X_PIX = 0, Y_PIX = 0;
  - Video_On = 0; HSync = VSync = !SYNC_ACT;
  - Pix_Tick = Line_End = Frame_Start = 0.
- Divider:
  - counts 0..CLK_DIV-1 while En = 1.
  - Pix_Tick is registered high for exactly one clk when the divider wraps.
  - First Pix_Tick appears CLK_DIV clks after the first enabled edge following reset release.
  - CLK_DIV = 1 holds Pix_Tick constantly high while En = 1.
- Counters, updated only on clk edges where Pix_Tick is asserted:
  - X increments and wraps H_TOTAL-1 -> 0.
  - Y increments on an X wrap and wraps V_TOTAL-1 -> 0.
  - Widths are 10 bits; the wrap is explicit compare, never natural overflow.
- Outputs are decoded from the counter next-state and registered on the same edge as the counters. X_PIX, Y_PIX, Video_On, HSync and VSync therefore always describe the same pixel, with zero extra latency.
- Decode rules:
  - Video_On = (X < H_ACTIVE) && (Y < V_ACTIVE).
  - HSync = SYNC_ACT when H_ACTIVE+H_FP <= X < H_ACTIVE+H_FP+H_SYNC (656..751), else !SYNC_ACT.
  - VSync = SYNC_ACT when V_ACTIVE+V_FP <= Y < V_ACTIVE+V_FP+V_SYNC (490..491), else !SYNC_ACT.
- Pulses (Line_End, Frame_Start) are asserted in the clk where the counters take value X = 0 (and Y = 0 for Frame_Start). They clear the following clk.
- En = 0:
  - divider, counters and all level outputs hold;
  - Pix_Tick, Line_End and Frame_Start are forced 0.
  - Resuming continues from the held state with no skipped or duplicated pixel.
- Reset mid-line or mid-frame: immediate return to reset values. The next frame starts cleanly at (0,0), with no Frame_Start pulse for the (0,0) reset state itself.
- After reset the first Frame_Start occurs at the wrap from (799,524).

Decomposition:
- Package vga_timing_pkg holds:
  - default timing constants for 640x480@60;
  - H_TOTAL/V_TOTAL computation functions;
  - a 10-bit coordinate typedef.
- One sub-module, pix_tick_div: parameterised CLK_DIV divider with En, producing Pix_Tick.
- Counters and decode live in vga_sync_gen.

Test Plan:
- Reset check: hold rst_n = 0, then release. Before the first tick: X_PIX = 0, Y_PIX = 0, Video_On = 0, HSync = VSync = 1. With CLK_DIV = 2, the first Pix_Tick occurs 2 clks after release.
- HSync timing, CLK_DIV = 2: HSync low for exactly 96 ticks (192 clks) while X_PIX runs 656..751. Line_End period = 1600 clks.
- Full-frame timing: Frame_Start pulses exactly 840000 clks apart. VSync low for 2 lines (3200 clks) at Y_PIX 490..491. Video_On is high for 307200 ticks per frame.
- Enable stall: drop En for 37 clks at X_PIX = 320. Outputs hold, no Pix_Tick is emitted, and X_PIX resumes 320 -> 321 after En returns.
- Asynchronous reset at X_PIX = 700, Y_PIX = 300, asserted between clk edges: outputs return to reset values immediately, without waiting for a clk edge. The frame restarts from (0,0).
- CLK_DIV = 1 variant: Pix_Tick is constantly high and Frame_Start period = 420000 clks.
